// File: rtl/hazard_pkg.sv
// Shared widths and forward-select encodings for the hazard unit.
package hazard_pkg;

  localparam int REGW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side view of the hazard unit: decode fields and stage flags in, stall/flush/forward controls out.
interface hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int RW = REGW
);

  logic [RW-1:0] rsd;
  logic [RW-1:0] rtd;
  logic [RW-1:0] rdd;
  logic          regdste;
  logic          branchd;
  logic          pcsrcd;
  logic          regwritee;
  logic          memtorege;
  logic          regwritem;
  logic          memtoregm;
  logic          regwritew;

  logic          stallf;
  logic          stalld;
  logic          flushe;
  logic          flushd;
  logic          forwardad;
  logic          forwardbd;
  logic [1:0]    forwardae;
  logic [1:0]    forwardbe;
  logic [RW-1:0] writerege;
  logic [RW-1:0] writeregm;
  logic [RW-1:0] writeregw;

  modport master (
    output rsd, rtd, rdd, regdste, branchd, pcsrcd,
           regwritee, memtorege, regwritem, memtoregm, regwritew,
    input  stallf, stalld, flushe, flushd, forwardad, forwardbd,
           forwardae, forwardbe, writerege, writeregm, writeregw
  );

  modport slave (
    input  rsd, rtd, rdd, regdste, branchd, pcsrcd,
           regwritee, memtorege, regwritem, memtoregm, regwritew,
    output stallf, stalld, flushe, flushd, forwardad, forwardbd,
           forwardae, forwardbe, writerege, writeregm, writeregw
  );

endinterface

// File: rtl/hazard_regtrack.sv
// Flushable E/M/W pipeline of register numbers, plus the E-stage destination mux.
module hazard_regtrack
  import hazard_pkg::*;
#(
  parameter int RW = REGW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flushe,
  input  logic [RW-1:0] rsd,
  input  logic [RW-1:0] rtd,
  input  logic [RW-1:0] rdd,
  input  logic          regdste,
  output logic [RW-1:0] rse,
  output logic [RW-1:0] rte,
  output logic [RW-1:0] rde,
  output logic [RW-1:0] writerege,
  output logic [RW-1:0] writeregm,
  output logic [RW-1:0] writeregw
);

  always_comb begin
    writerege = regdste ? rde : rte;
  end

  // Stall needs no separate hold here: flushe is always raised alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rse       <= '0;
      rte       <= '0;
      rde       <= '0;
      writeregm <= '0;
      writeregw <= '0;
    end else begin
      if (flushe) begin
        rse <= '0;
        rte <= '0;
        rde <= '0;
      end else begin
        rse <= rsd;
        rte <= rtd;
        rde <= rdd;
      end
      writeregm <= writerege;
      writeregw <= writeregm;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the five-stage MIPS pipeline.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int RW = REGW
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz
);

  logic [RW-1:0] rse;
  logic [RW-1:0] rte;
  logic [RW-1:0] rde;
  logic [RW-1:0] writerege;
  logic [RW-1:0] writeregm;
  logic [RW-1:0] writeregw;
  logic          lwstall;
  logic          branchstall;
  logic          stall;

  hazard_regtrack #(.RW(RW)) u_track (
    .clk       (clk),
    .reset     (reset),
    .flushe    (stall),
    .rsd       (hz.rsd),
    .rtd       (hz.rtd),
    .rdd       (hz.rdd),
    .regdste   (hz.regdste),
    .rse       (rse),
    .rte       (rte),
    .rde       (rde),
    .writerege (writerege),
    .writeregm (writeregm),
    .writeregw (writeregw)
  );

  // Register 0 is hardwired, so it is never a forwarding source; M wins over W.
  function automatic fwd_e ex_fwd(input logic [RW-1:0] rs, input logic [RW-1:0] wm,
                                  input logic rwm, input logic [RW-1:0] ww, input logic rww);
    fwd_e sel;
    sel = FWD_RF;
    if (rs != '0 && rs == wm && rwm)
      sel = FWD_MEM;
    else if (rs != '0 && rs == ww && rww)
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    hz.forwardae = ex_fwd(rse, writeregm, hz.regwritem, writeregw, hz.regwritew);
    hz.forwardbe = ex_fwd(rte, writeregm, hz.regwritem, writeregw, hz.regwritew);
    hz.forwardad = (hz.rsd != '0) && (hz.rsd == writeregm) && hz.regwritem;
    hz.forwardbd = (hz.rtd != '0) && (hz.rtd == writeregm) && hz.regwritem;
  end

  // Stall compares deliberately include $0; a spurious bubble there is harmless.
  always_comb begin
    lwstall     = hz.memtorege && ((rte == hz.rsd) || (rte == hz.rtd));
    branchstall = hz.branchd &&
                  ((hz.regwritee && ((writerege == hz.rsd) || (writerege == hz.rtd))) ||
                   (hz.memtoregm && ((writeregm == hz.rsd) || (writeregm == hz.rtd))));
    stall       = lwstall || branchstall;
    hz.stallf    = stall;
    hz.stalld    = stall;
    hz.flushe    = stall;
    hz.flushd    = hz.pcsrcd && !stall;
    hz.writerege = writerege;
    hz.writeregm = writeregm;
    hz.writeregw = writeregw;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, branch stalls, flushes and reset.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  hazard_unit_if #(.RW(5)) hz ();

  hazard_unit #(.RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    hz.rsd = rs;
    hz.rtd = rt;
    hz.rdd = rd;
  endtask

  task automatic flags(input logic rwe, input logic mte, input logic rwm,
                       input logic mtm, input logic rww);
    hz.regwritee = rwe;
    hz.memtorege = mte;
    hz.regwritem = rwm;
    hz.memtoregm = mtm;
    hz.regwritew = rww;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Reset with random inputs
    reset = 1'b1;
    dec(5'($urandom), 5'($urandom), 5'($urandom));
    flags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    hz.regdste = 1'($urandom);
    hz.branchd = 1'($urandom);
    hz.pcsrcd  = 1'($urandom);
    tick();
    tick();
    reset = 1'b0;
    dec(0, 0, 0);
    flags(0, 0, 0, 0, 0);
    hz.regdste = 1'b0;
    hz.branchd = 1'b0;
    hz.pcsrcd  = 1'b0;
    #1;
    check("rst_rse", 32'(dut.u_track.rse), 0);
    check("rst_rte", 32'(dut.u_track.rte), 0);
    check("rst_rde", 32'(dut.u_track.rde), 0);
    check("rst_wre", 32'(hz.writerege), 0);
    check("rst_wrm", 32'(hz.writeregm), 0);
    check("rst_wrw", 32'(hz.writeregw), 0);
    check("rst_flushe", 32'(hz.flushe), 0);
    check("rst_fae", 32'(hz.forwardae), 0);

    // ALU chain: add $3,$1,$2 ; sub $4,$3,$5 ; and $6,$3,$0
    dec(1, 2, 3);
    tick();
    dec(3, 5, 4);
    hz.regdste = 1'b1;
    flags(1, 0, 0, 0, 0);
    #1;
    check("alu_wre", 32'(hz.writerege), 3);
    check("alu_fad0", 32'(hz.forwardad), 0);
    tick();
    dec(3, 0, 6);
    flags(1, 0, 1, 0, 0);
    #1;
    check("alu_fae_mem", 32'(hz.forwardae), 2'b10);
    check("alu_fbe_rf", 32'(hz.forwardbe), 2'b00);
    check("alu_fad_m", 32'(hz.forwardad), 1);
    check("alu_nostall", 32'(hz.stallf), 0);
    tick();
    dec(0, 0, 0);
    flags(1, 0, 1, 0, 1);
    #1;
    check("alu_fae_wb", 32'(hz.forwardae), 2'b01);
    check("alu_fbe_r0", 32'(hz.forwardbe), 2'b00);
    tick();
    flags(0, 0, 1, 0, 1);
    tick();
    #1;
    check("r0_wrm", 32'(hz.writeregm), 0);
    check("r0_fae", 32'(hz.forwardae), 2'b00);
    check("r0_fad", 32'(hz.forwardad), 0);
    check("r0_wrw", 32'(hz.writeregw), 6);

    // Load-use: lw $2,0($1) ; add $4,$2,$5
    flags(0, 0, 0, 0, 0);
    hz.regdste = 1'b0;
    dec(1, 2, 0);
    tick();
    flags(1, 1, 0, 0, 0);
    dec(2, 5, 4);
    #1;
    check("lu_stallf", 32'(hz.stallf), 1);
    check("lu_stalld", 32'(hz.stalld), 1);
    check("lu_flushe", 32'(hz.flushe), 1);
    check("lu_flushd", 32'(hz.flushd), 0);
    tick();
    flags(0, 0, 1, 1, 0);
    #1;
    check("lu_stall_drop", 32'(hz.stallf), 0);
    check("lu_flushe_drop", 32'(hz.flushe), 0);
    check("lu_rse0", 32'(dut.u_track.rse), 0);
    check("lu_rte0", 32'(dut.u_track.rte), 0);
    check("lu_rde0", 32'(dut.u_track.rde), 0);
    tick();
    flags(0, 0, 0, 0, 1);
    dec(0, 0, 0);
    #1;
    check("lu_fae_wb", 32'(hz.forwardae), 2'b01);
    tick();

    // Branch after load: lw $7,0($1) ; beq $7,$0 (taken)
    flags(0, 0, 0, 0, 0);
    dec(1, 7, 0);
    tick();
    flags(1, 1, 0, 0, 0);
    hz.branchd = 1'b1;
    hz.pcsrcd  = 1'b1;
    dec(7, 0, 0);
    #1;
    check("bl_stall1", 32'(hz.stalld), 1);
    check("bl_flushd_stalled", 32'(hz.flushd), 0);
    tick();
    flags(0, 0, 1, 1, 0);
    #1;
    check("bl_stall2", 32'(hz.stallf), 1);
    check("bl_flushd_stalled2", 32'(hz.flushd), 0);
    tick();
    flags(0, 0, 0, 0, 1);
    #1;
    check("bl_stall3", 32'(hz.stallf), 0);
    check("bl_fad3", 32'(hz.forwardad), 0);
    check("bl_flushd_taken", 32'(hz.flushd), 1);
    tick();

    // Branch after ALU op: add $7,$1,$2 ; beq $7,$0 (not taken)
    hz.branchd = 1'b0;
    hz.pcsrcd  = 1'b0;
    flags(0, 0, 0, 0, 0);
    dec(1, 2, 7);
    tick();
    hz.regdste = 1'b1;
    flags(1, 0, 0, 0, 0);
    hz.branchd = 1'b1;
    dec(7, 0, 0);
    #1;
    check("ba_stall1", 32'(hz.stalld), 1);
    tick();
    flags(0, 0, 1, 0, 0);
    #1;
    check("ba_stall2", 32'(hz.stalld), 0);
    check("ba_fad", 32'(hz.forwardad), 1);
    check("ba_fbd_r0", 32'(hz.forwardbd), 0);
    tick();

    // M and W both write $9: sub $10,$1,$9 sees M priority
    hz.branchd = 1'b0;
    flags(0, 0, 0, 0, 0);
    dec(1, 2, 9);
    tick();
    flags(1, 0, 0, 0, 0);
    tick();
    flags(1, 0, 1, 0, 0);
    dec(1, 9, 10);
    #1;
    check("pr_fbd", 32'(hz.forwardbd), 1);
    tick();
    flags(1, 0, 1, 0, 1);
    dec(0, 0, 0);
    #1;
    check("pr_wrm", 32'(hz.writeregm), 9);
    check("pr_wrw", 32'(hz.writeregw), 9);
    check("pr_fbe_mem", 32'(hz.forwardbe), 2'b10);
    check("pr_fae_rf", 32'(hz.forwardae), 2'b00);

    // Reset asserted during a load-use stall
    flags(0, 1, 0, 0, 0);
    dec(0, 9, 0);
    #1;
    check("rs_stall_pre", 32'(hz.flushe), 1);
    reset = 1'b1;
    tick();
    check("rs_rte", 32'(dut.u_track.rte), 0);
    check("rs_wrm", 32'(hz.writeregm), 0);
    check("rs_wrw", 32'(hz.writeregw), 0);
    reset = 1'b0;
    flags(0, 0, 0, 0, 0);
    #1;
    check("rs_stall_post", 32'(hz.stallf), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
